// File: rtl/rol64_pkg.sv
// ============================================================================
// Module      : rol64_pkg
// Description : Shared widths and behavioural rotate reference for rol64_core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rol64_pkg;

    localparam int ROL_BW_A   = 64;
    localparam int ROL_BW_N   = 9;
    localparam int ROL_NSTAGE = $clog2(ROL_BW_A);

    // Behavioural rotate-left; only the low ROL_NSTAGE bits of n matter.
    function automatic logic [ROL_BW_A-1:0] rol_ref(
        input logic [ROL_BW_A-1:0] a,
        input logic [ROL_BW_N-1:0] n
    );
        logic [ROL_NSTAGE-1:0] k;
        k = n[ROL_NSTAGE-1:0];
        if (k == '0) begin
            return a;
        end
        return (a << k) | (a >> (ROL_BW_A - int'(k)));
    endfunction

endpackage

`default_nettype wire

// File: rtl/rol64_core_stage.sv
// ============================================================================
// Module      : rol_stage
// Description : One barrel-rotator stage: rotate left by SHIFT when selected.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rol_stage
    import rol64_pkg::*;
#(
    parameter int BW_A  = ROL_BW_A,
    parameter int SHIFT = 1
) (
    input  logic [BW_A-1:0] i_d,
    input  logic            i_sel,
    output logic [BW_A-1:0] o_d
);

    logic [BW_A-1:0] w_rot;

    assign w_rot = {i_d[BW_A-SHIFT-1:0], i_d[BW_A-1:BW_A-SHIFT]};
    assign o_d   = i_sel ? w_rot : i_d;

endmodule

`default_nettype wire

// File: rtl/rol64_core.sv
// ============================================================================
// Module      : rol64_core
// Description : Registered log2(BW_A)-stage barrel rotator, 1-cycle latency.
//               Define ROL64_ROR_EN to add the i_dir (rotate-right) port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rol64_core
    import rol64_pkg::*;
#(
    parameter int BW_A = ROL_BW_A,
    parameter int BW_N = ROL_BW_N
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [BW_A-1:0] i_a,
    input  logic [BW_N-1:0] i_n,
`ifdef ROL64_ROR_EN
    input  logic            i_dir,
`endif
    output logic            o_valid,
    output logic [BW_A-1:0] o_rol64
);

    localparam int NSTAGE = $clog2(BW_A);

    logic [NSTAGE-1:0] w_k_raw;
    logic [NSTAGE-1:0] w_k;
    logic [BW_A-1:0]   w_stage [0:NSTAGE];
    logic              r_valid;
    logic [BW_A-1:0]   r_rol64;

    assign w_k_raw = i_n[NSTAGE-1:0];

`ifdef ROL64_ROR_EN
    // Rotate right by k equals rotate left by (BW_A-k) mod BW_A, i.e. -k.
    assign w_k = i_dir ? (~w_k_raw + NSTAGE'(1)) : w_k_raw;
`else
    assign w_k = w_k_raw;
`endif

    generate
        if (BW_N > NSTAGE) begin : g_n_upper
            logic w_n_unused;
            assign w_n_unused = ^i_n[BW_N-1:NSTAGE];
        end
    endgenerate

    assign w_stage[0] = i_a;

    generate
        for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
            rol_stage #(
                .BW_A  (BW_A),
                .SHIFT (1 << s)
            ) u_stage (
                .i_d   (w_stage[s]),
                .i_sel (w_k[s]),
                .o_d   (w_stage[s+1])
            );
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_rol64 <= '0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_rol64 <= w_stage[NSTAGE];
            end
        end
    end

    assign o_valid = r_valid;
    assign o_rol64 = r_rol64;

endmodule

`default_nettype wire

// File: tb/tb_rol64_core.sv
// ============================================================================
// Module      : tb_rol64_core
// Description : Directed-vector self-checking bench for rol64_core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rol64_core;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [63:0] a;
    logic [8:0]  n;
    logic        dir;
    logic        o_valid;
    logic [63:0] o_rol64;

    int n_cmp  = 0;
    int n_fail = 0;

    rol64_core u_dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (valid),
        .i_a     (a),
        .i_n     (n),
`ifdef ROL64_ROR_EN
        .i_dir   (dir),
`endif
        .o_valid (o_valid),
        .o_rol64 (o_rol64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-by-bit model: bit i of the operand lands at bit (i+k) mod 64.
    function automatic logic [63:0] model_rotl(input logic [63:0] x, input int amt);
        logic [63:0] r;
        int k;
        k = amt % 64;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            r[(i + k) % 64] = x[i];
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        valid = 1'b1;
        a     = 64'hFFFF_FFFF_FFFF_FFFF;
        n     = 9'd1;
        dir   = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            n_cmp++;
            if (o_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_valid cyc%0d: got %b want 0", c, o_valid);
            end
            n_cmp++;
            if (o_rol64 !== 64'h0) begin
                n_fail++;
                $display("FAIL reset_data cyc%0d: got %h want 0", c, o_rol64);
            end
        end
        rst   = 1'b0;
        valid = 1'b0;
        step();
        n_cmp++;
        if (o_valid !== 1'b0 || o_rol64 !== 64'h0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got v=%b d=%h want v=0 d=0", o_valid, o_rol64);
        end
    endtask

    task automatic test_basic();
        valid = 1'b1;
        a = 64'h0000_0000_0000_0001; n = 9'd1;
        step();
        n_cmp++;
        if (o_valid !== 1'b1 || o_rol64 !== 64'h0000_0000_0000_0002) begin
            n_fail++;
            $display("FAIL basic_1: got v=%b d=%h want v=1 d=0000000000000002", o_valid, o_rol64);
        end
        a = 64'h8000_0000_0000_0000; n = 9'd1;
        step();
        n_cmp++;
        if (o_valid !== 1'b1 || o_rol64 !== 64'h0000_0000_0000_0001) begin
            n_fail++;
            $display("FAIL basic_wrap: got v=%b d=%h want v=1 d=0000000000000001", o_valid, o_rol64);
        end
    endtask

    task automatic test_modulo();
        logic [8:0] amts [3];
        amts[0] = 9'd0; amts[1] = 9'd64; amts[2] = 9'd448;
        valid = 1'b1;
        a = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i < 3; i++) begin
            n = amts[i];
            step();
            n_cmp++;
            if (o_rol64 !== 64'h0123_4567_89AB_CDEF) begin
                n_fail++;
                $display("FAIL modulo_n%0d: got %h want 0123456789abcdef", amts[i], o_rol64);
            end
        end
        n = 9'd68;
        step();
        n_cmp++;
        if (o_rol64 !== 64'h1234_5678_9ABC_DEF0) begin
            n_fail++;
            $display("FAIL modulo_n68: got %h want 123456789abcdef0", o_rol64);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_d;
        valid = 1'b1;
        for (int i = 0; i < 512; i++) begin
            a = {$urandom, $urandom};
            n = 9'(i);
            exp_d = model_rotl(a, i);
            step();
            n_cmp++;
            if (o_valid !== 1'b1 || o_rol64 !== exp_d) begin
                n_fail++;
                $display("FAIL sweep_n%0d: got v=%b d=%h want v=1 d=%h", i, o_valid, o_rol64, exp_d);
            end
        end
    endtask

    task automatic test_hold();
        logic [63:0] held;
        valid = 1'b1;
        a = 64'hDEAD_BEEF_0000_0001; n = 9'd8;
        held = 64'hADBE_EF00_0000_01DE;
        step();
        n_cmp++;
        if (o_rol64 !== held) begin
            n_fail++;
            $display("FAIL hold_load: got %h want %h", o_rol64, held);
        end
        valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            a = 64'h1111_2222_3333_4444 + 64'(c);
            n = 9'(c + 3);
            step();
            n_cmp++;
            if (o_valid !== 1'b0 || o_rol64 !== held) begin
                n_fail++;
                $display("FAIL hold_gap%0d: got v=%b d=%h want v=0 d=%h", c, o_valid, o_rol64, held);
            end
        end
        // A valid op on a reset edge must be discarded.
        rst = 1'b1; valid = 1'b1;
        step();
        n_cmp++;
        if (o_valid !== 1'b0 || o_rol64 !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_priority: got v=%b d=%h want v=0 d=0", o_valid, o_rol64);
        end
        rst = 1'b0; valid = 1'b0;
        step();
    endtask

`ifdef ROL64_ROR_EN
    task automatic test_ror();
        valid = 1'b1;
        dir = 1'b1; a = 64'h0000_0000_0000_0001; n = 9'd1;
        step();
        n_cmp++;
        if (o_rol64 !== 64'h8000_0000_0000_0000) begin
            n_fail++;
            $display("FAIL ror_1: got %h want 8000000000000000", o_rol64);
        end
        a = 64'h0123_4567_89AB_CDEF; n = 9'd68;
        step();
        n_cmp++;
        if (o_rol64 !== 64'hF012_3456_789A_BCDE) begin
            n_fail++;
            $display("FAIL ror_68: got %h want f0123456789abcde", o_rol64);
        end
        n = 9'd64;
        step();
        n_cmp++;
        if (o_rol64 !== 64'h0123_4567_89AB_CDEF) begin
            n_fail++;
            $display("FAIL ror_0: got %h want 0123456789abcdef", o_rol64);
        end
        dir = 1'b0; n = 9'd68;
        step();
        n_cmp++;
        if (o_rol64 !== 64'h1234_5678_9ABC_DEF0) begin
            n_fail++;
            $display("FAIL rol_dir0: got %h want 123456789abcdef0", o_rol64);
        end
        valid = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_modulo();
        test_back_to_back();
        test_hold();
`ifdef ROL64_ROR_EN
        test_ror();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rol64_core.md
Name: rol64_core

Overview:
- Synchronous 64-bit rotate-left unit for the Keccak permutation datapath (rho step, theta column rotate) inside the Kyber hardware.
- Rotates operand i_a left by i_n modulo the word width.
- Implemented as a log2(BW_A)-stage barrel rotator with a registered, valid-qualified output.
- Serves as a drop-in registered replacement for the combinational rotate primitive.

Parameters:
- BW_A, 64, operand/result width in bits; must be a power of two ≥ 2.
- BW_N, 9, width of rotate-amount input; only the low log2(BW_A) bits are used.

Ports:
- i_clk  input  1  rising-edge clock.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  i_a/i_n are valid this cycle.
- i_a  input  BW_A  operand.
- i_n  input  BW_N  rotate amount.
- o_valid  output  1  o_rol64 holds a new result.
- o_rol64  output  BW_A  rotated result.
- i_dir  input  1  0 = rotate left, 1 = rotate right; present only when ROL64_ROR_EN is defined.

Behaviour:
- Effective amount is k = i_n mod BW_A, i.e. i_n[log2(BW_A)-1:0]. Upper bits of i_n are ignored, so i_n=64, 128 and 320 all give k=0.
- Result: o_rol64 = (i_a << k) | (i_a >> (BW_A-k)), truncated to BW_A bits. k=0 returns i_a unchanged.
- Datapath: log2(BW_A) cascaded stages. Stage s rotates by 2^s when k[s]=1 and otherwise passes through. All stages are combinational.
- One register holds the result and valid. Latency is exactly 1 cycle: inputs sampled at edge t appear on o_rol64/o_valid after edge t.
- Throughput is one operation per cycle, with no stall and no back-pressure.
- o_valid: registered copy of i_valid.
- o_rol64 updates only when i_valid=1. When i_valid=0 it holds its previous value.
- Reset: when i_rst=1 at a rising edge, o_valid←0 and o_rol64←0. Reset has priority over a simultaneous i_valid.
- A valid input presented on a reset cycle is discarded.
- First result after reset release needs i_valid=1 on a non-reset edge.
- No X propagation: every register has a reset value.

Optional Feature:
- Macro: ROL64_ROR_EN.
- Defined:
  - Port i_dir exists.
  - i_dir=1 gives a rotate right by k: (i_a >> k) | (i_a << (BW_A-k)).
  - Implemented by replacing k with (BW_A-k) mod BW_A before the stages.
  - Latency is unchanged.
- Undefined:
  - Port i_dir is absent.
  - Rotate-left only, as above.

Decomposition:
- Package rol64_pkg:
  - ROL_BW_A=64, ROL_BW_N=9.
  - ROL_NSTAGE = $clog2(ROL_BW_A).
  - Function rol_ref(a,n), the behavioural reference for the verifier.
- Sub-module rol_stage (parameters BW_A, SHIFT):
  - Ports: i_d, i_sel → o_d.
  - o_d = i_sel ? rotl(i_d, SHIFT) : i_d.
  - Generated ROL_NSTAGE times in rol64_core.

Test Plan:
- Reset:
  - Hold i_rst=1 two cycles with i_valid=1 and i_a=FFFF_FFFF_FFFF_FFFF.
  - Required: o_valid=0 and o_rol64=0 throughout.
- Basic rotate:
  - i_a=0000_0000_0000_0001, i_n=1 → next cycle o_rol64=0000_0000_0000_0002, o_valid=1.
  - i_a=8000_0000_0000_0000, i_n=1 → o_rol64=0000_0000_0000_0001.
- Modulo amount:
  - i_a=0123_4567_89AB_CDEF with i_n=0, 64 and 448 → o_rol64=0123_4567_89AB_CDEF for each.
  - Same i_a with i_n=68 → o_rol64=1234_5678_9ABC_DEF0.
- Full-range sweep:
  - Random i_a, i_n swept 0..511, back-to-back valid every cycle.
  - Required: each result equals rol_ref(i_a, i_n) exactly one cycle later; 100+ vectors, zero mismatches.
- Hold/valid gaps:
  - Valid op, then three cycles with i_valid=0 and changing i_a.
  - Required: o_valid drops to 0 and o_rol64 holds the last result.
- Optional ROL64_ROR_EN:
  - i_dir=1, i_a=0000_0000_0000_0001, i_n=1 → o_rol64=8000_0000_0000_0000.
  - i_dir=0 results are identical to the left-only build.
